// File: rtl/imem_scrub_ctrl.sv
// imem_scrub_ctrl: background ECC scrubber for an instruction memory.
// Sweeps every word at a fixed idle interval and re-writes words that show
// correctable errors. Uncorrectable errors are counted but never written back.
// CPU fetches own the read port and loader writes own the write port. A
// starvation counter guarantees the scrubber gets one read slot eventually.
// Optional feature: define SCRUB_UE_LOG_EN to latch the address of the last
// uncorrectable word (ue_addr) and pulse ue_irq. When it is undefined both
// outputs are tied to 0.
module imem_scrub_ctrl #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned INTERVAL = 256,
    parameter int unsigned STARVE   = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scrub_en,
    input  logic             clr_cnt,
    input  logic             cpu_req,
    input  logic [31:0]      cpu_addr,
    output logic             cpu_gnt,
    input  logic             ld_req,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_data,
    output logic             ld_ack,
    output logic [31:0]      mem_raddr,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_s_err,
    input  logic             mem_d_err,
    output logic             mem_we,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic [CNT_W-1:0] ce_count,
    output logic [CNT_W-1:0] ue_count,
    output logic             sweep_done,
    output logic             ue_irq,
    output logic [31:0]      ue_addr,
    output logic             scrub_busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int unsigned SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ,
        FIX
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_idx;
    logic [IW-1:0]    r_wcnt;
    logic [SW-1:0]    r_starve;
    logic [31:0]      r_fix_data;
    logic [CNT_W-1:0] r_ce;
    logic [CNT_W-1:0] r_ue;
    logic             r_sweep_done;

    logic [31:0]      w_idx_addr;
    logic             w_starved;
    logic             w_scrub_rd;
    logic             w_ce_hit;
    logic             w_ue_hit;
    logic             w_ld_hit;
    logic             w_fix_wr;
    logic             w_fix_cancel;
    logic             w_advance;
    logic             w_wrap;

    assign w_idx_addr   = 32'({r_idx, 2'b00});
    assign w_starved    = (r_starve >= SW'(STARVE));
    // The scrubber owns the read port only in READ, and only when the CPU is
    // idle or has starved the scrubber long enough.
    assign w_scrub_rd   = (r_state == READ) && scrub_en && (!cpu_req || w_starved);
    assign w_ue_hit     = w_scrub_rd && mem_d_err;
    assign w_ce_hit     = w_scrub_rd && mem_s_err && !mem_d_err;
    assign w_ld_hit     = ld_req && (ld_addr[AW+1:2] == r_idx);
    assign w_fix_wr     = (r_state == FIX) && !ld_req;
    // A loader write to the word being repaired makes the captured data stale.
    assign w_fix_cancel = (r_state == FIX) && w_ld_hit;
    assign w_advance    = (w_scrub_rd && !w_ce_hit) || w_fix_wr || w_fix_cancel;
    assign w_wrap       = w_advance && (r_idx == AW'(DEPTH - 1));

    // Port arbitration: CPU wins the read port, loader wins the write port.
    always_comb begin
        cpu_gnt   = cpu_req && !w_scrub_rd;
        mem_raddr = w_scrub_rd ? w_idx_addr : cpu_addr;
        mem_we    = rst_n && (ld_req || w_fix_wr);
        ld_ack    = rst_n && ld_req;
        mem_waddr = ld_req ? ld_addr : w_idx_addr;
        mem_wdata = ld_req ? ld_data : r_fix_data;
    end

    // Sweep FSM with word index, interval timer and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_wcnt       <= '0;
            r_starve     <= '0;
            r_fix_data   <= '0;
            r_sweep_done <= 1'b0;
        end else begin
            r_sweep_done <= w_wrap;
            if (w_advance) begin
                r_idx <= r_idx + AW'(1);
            end
            case (r_state)
                IDLE: begin
                    r_starve <= '0;
                    if (scrub_en) begin
                        r_state <= WAIT;
                        r_wcnt  <= IW'(INTERVAL - 1);
                    end
                end
                WAIT: begin
                    if (!scrub_en) begin
                        r_state <= IDLE;
                    end else if (r_wcnt == '0) begin
                        r_state <= READ;
                    end else begin
                        r_wcnt <= r_wcnt - IW'(1);
                    end
                end
                READ: begin
                    if (!scrub_en) begin
                        r_state  <= IDLE;
                        r_starve <= '0;
                    end else if (w_scrub_rd) begin
                        r_starve <= '0;
                        if (w_ce_hit) begin
                            r_fix_data <= mem_rdata;
                            r_state    <= FIX;
                        end else begin
                            r_state <= WAIT;
                            r_wcnt  <= IW'(INTERVAL - 1);
                        end
                    end else begin
                        r_starve <= r_starve + SW'(1);
                    end
                end
                FIX: begin
                    // Leaving FIX waits for the write-back even if scrub_en drops.
                    if (w_fix_wr || w_fix_cancel) begin
                        r_state <= scrub_en ? WAIT : IDLE;
                        r_wcnt  <= IW'(INTERVAL - 1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating error counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce <= '0;
            r_ue <= '0;
        end else if (clr_cnt) begin
            r_ce <= '0;
            r_ue <= '0;
        end else begin
            if (w_ce_hit && (r_ce != '1)) begin
                r_ce <= r_ce + CNT_W'(1);
            end
            if (w_ue_hit && (r_ue != '1)) begin
                r_ue <= r_ue + CNT_W'(1);
            end
        end
    end

    assign ce_count   = r_ce;
    assign ue_count   = r_ue;
    assign sweep_done = r_sweep_done;
    assign scrub_busy = (r_state == READ) || (r_state == FIX);

`ifdef SCRUB_UE_LOG_EN
    logic [31:0] r_ue_addr;
    logic        r_ue_irq;

    // Latch the failing word address and raise a one-cycle interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ue_addr <= '0;
            r_ue_irq  <= 1'b0;
        end else begin
            r_ue_irq <= w_ue_hit;
            if (w_ue_hit) begin
                r_ue_addr <= w_idx_addr;
            end
        end
    end

    assign ue_addr = r_ue_addr;
    assign ue_irq  = r_ue_irq;
`else
    assign ue_addr = '0;
    assign ue_irq  = 1'b0;
`endif

endmodule
